// File: rtl/dispense_pkg.sv
// Shared amount codes and FSM state encoding for the candy dispense sequencer.
package dispense_pkg;

  localparam logic [1:0] AMT_SMALL   = 2'b00;
  localparam logic [1:0] AMT_MED     = 2'b01;
  localparam logic [1:0] AMT_LARGE   = 2'b10;
  localparam logic [1:0] AMT_INVALID = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/pi_input_sync.sv
// Parameterized-width two-flop synchronizer for the asynchronous Raspberry Pi GPIO bits.
module pi_input_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/dispense_sequencer.sv
// Turns a debounced Pi dispense request into a counted, self-terminating stepper run
// with DC agitator enable and a completion handshake back to the Pi.
module dispense_sequencer
  import dispense_pkg::*;
#(
  parameter int STEP_HALF   = 1000,
  parameter int STEPS_SMALL = 200,
  parameter int STEPS_MED   = 400,
  parameter int STEPS_LARGE = 600,
  parameter int DEBOUNCE    = 2000,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       candy_flag_i,
  input  logic [1:0] amount_i,
  output logic       step_o,
  output logic       dir_o,
  output logic       dc_en_o,
  output logic       busy_o,
  output logic       handshake_o,
  output logic       err_o,
  output logic [1:0] state_o
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(STEP_HALF - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Pi protocol: the Pi raises candy_flag_i and holds it; the sequencer answers with
  // handshake_o after a complete run and keeps it until the Pi drops the flag.
  // Dropping the flag early aborts the run and reports err_o instead.
  logic [2:0] sync_q;
  logic       flag_s;
  logic [1:0] amt_s;

  pi_input_sync #(.W(3)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({candy_flag_i, amount_i}),
    .q   (sync_q)
  );

  assign flag_s = sync_q[2];
  assign amt_s  = sync_q[1:0];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic             invalid_q, invalid_d;
  logic             step_q, step_d;
  logic             dc_en_q, dc_en_d;
  logic             busy_q, busy_d;
  logic             hs_q, hs_d;
  logic             err_q, err_d;

  function automatic logic [CNT_W-1:0] target_for(input logic [1:0] amt);
    case (amt)
      AMT_MED:   return CNT_W'(STEPS_MED);
      AMT_LARGE: return CNT_W'(STEPS_LARGE);
      default:   return CNT_W'(STEPS_SMALL);
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    step_cnt_d = step_cnt_q;
    target_d   = target_q;
    invalid_d  = invalid_q;
    step_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (flag_s) begin
          state_d = ST_ARM;
          timer_d = '0;
        end
      end

      ST_ARM: begin
        if (!flag_s) begin
          state_d = ST_IDLE;
        end else if (timer_q == DEB_LAST) begin
          if (amt_s == AMT_INVALID) begin
            err_d     = 1'b1;
            invalid_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            invalid_d  = 1'b0;
            target_d   = target_for(amt_s);
            step_cnt_d = '0;
            timer_d    = '0;
            step_d     = 1'b1;
            state_d    = ST_RUN;
          end
        end else begin
          timer_d = (timer_q == CNT_MAX) ? timer_q : timer_q + CNT_ONE;
        end
      end

      ST_RUN: begin
        // Abort is checked first so it wins over a run finishing on the same cycle.
        if (!flag_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (timer_q == HALF_LAST) begin
          timer_d = '0;
          if (step_q) begin
            step_cnt_d = (step_cnt_q == CNT_MAX) ? step_cnt_q : step_cnt_q + CNT_ONE;
          end else if (step_cnt_q >= target_q) begin
            // The last step was counted on its falling edge; finishing after its low
            // half keeps the run at exactly two half periods per step.
            state_d = ST_DONE;
          end else begin
            step_d = 1'b1;
          end
        end else begin
          timer_d = (timer_q == CNT_MAX) ? timer_q : timer_q + CNT_ONE;
          step_d  = step_q;
        end
      end

      ST_DONE: begin
        if (!flag_s) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d == ST_ARM) || (state_d == ST_RUN);
    dc_en_d = (state_d == ST_RUN);
    hs_d    = (state_d == ST_DONE) && !invalid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      step_cnt_q <= '0;
      target_q   <= '0;
      invalid_q  <= 1'b0;
      step_q     <= 1'b0;
      dc_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      hs_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      step_cnt_q <= step_cnt_d;
      target_q   <= target_d;
      invalid_q  <= invalid_d;
      step_q     <= step_d;
      dc_en_q    <= dc_en_d;
      busy_q     <= busy_d;
      hs_q       <= hs_d;
      err_q      <= err_d;
    end
  end

  assign step_o      = step_q;
  assign dir_o       = 1'b0;
  assign dc_en_o     = dc_en_q;
  assign busy_o      = busy_q;
  assign handshake_o = hs_q;
  assign err_o       = err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Bench for dispense_sequencer: table of dispense scenarios scored per run, plus
// hand-written reset and reset-mid-run sequences.
module tb_dispense_sequencer;
  import dispense_pkg::*;

  localparam int W = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       candy_flag_i = 1'b0;
  logic [1:0] amount_i = 2'b00;
  logic       step_o, dir_o, dc_en_o, busy_o, handshake_o, err_o;
  logic [1:0] state_o;

  dispense_sequencer #(
    .STEP_HALF   (4),
    .STEPS_SMALL (5),
    .STEPS_MED   (6),
    .STEPS_LARGE (7),
    .DEBOUNCE    (8),
    .CNT_W       (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .candy_flag_i (candy_flag_i),
    .amount_i     (amount_i),
    .step_o       (step_o),
    .dir_o        (dir_o),
    .dc_en_o      (dc_en_o),
    .busy_o       (busy_o),
    .handshake_o  (handshake_o),
    .err_o        (err_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] amt;
    int         hold;   // cycles the flag stays high; 0 = until DONE is reached
    int         chg;    // cycle at which amount_i is changed to 00; 0 = never
    int         steps;
    int         dc;
    int         hs;
    int         err;
  } vec_t;

  vec_t         vecs[9];
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;

  int   n_steps, n_dc, n_hs, n_err, n_viol, lat;
  logic prev_step;

  function automatic logic [W-1:0] make_rec(input int s, input int d, input int h,
                                            input int e, input int v, input int l);
    return {s[7:0], d[7:0], 3'b000, h[0], e[3:0], 3'b000, v[0], l[3:0]};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_counters();
    n_steps = 0; n_dc = 0; n_hs = 0; n_err = 0; n_viol = 0; lat = 0;
    prev_step = 1'b0;
  endtask

  task automatic sample();
    if (step_o && !prev_step) n_steps++;
    prev_step = step_o;
    if (dc_en_o) n_dc++;
    if (handshake_o) n_hs = 1;
    if (err_o) n_err++;
    if ((step_o && !dc_en_o) || dir_o) n_viol = 1;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int   cyc;
    int   drop;
    logic done;
    exp_q.push_back(make_rec(v.steps, v.dc, v.hs, v.err, 0, 3));
    clear_counters();
    amount_i     = v.amt;
    candy_flag_i = 1'b1;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      sample();
      if (busy_o && lat == 0) lat = cyc;
      if (v.chg > 0 && cyc == v.chg) amount_i = 2'b00;
      if (v.hold > 0) begin
        if (cyc == v.hold) candy_flag_i = 1'b0;
        if (cyc >= v.hold + 3 && state_o == ST_IDLE) done = 1'b1;
      end else if (state_o == ST_DONE) begin
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no end of run within 400 cycles, state %0d", name, state_o);
      candy_flag_i = 1'b0;
    end else if (v.hold == 0) begin
      repeat (5) begin
        @(posedge clk); #1;
        sample();
      end
      candy_flag_i = 1'b0;
      drop = 0;
      for (int i = 1; i <= 6; i++) begin
        @(posedge clk); #1;
        if (!handshake_o && drop == 0) drop = i;
        sample();
      end
      if (v.hs != 0) check({name, "_hs_drop"}, W'(drop), W'(3));
    end
    repeat (4) @(posedge clk);
    #1;
    check(name, make_rec(n_steps, n_dc, n_hs, n_err, n_viol, lat), exp_q.pop_front());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          amt    hold chg steps dc  hs err
    vecs[0] = '{2'b00, 0,   0,  5,    40, 1, 0};  // small dispense
    vecs[1] = '{2'b10, 0,   20, 7,    56, 1, 0};  // large, amount changed mid-run
    vecs[2] = '{2'b00, 5,   0,  0,    0,  0, 0};  // glitch shorter than debounce
    vecs[3] = '{2'b01, 30,  0,  3,    22, 0, 1};  // abort after 3 pulses
    vecs[4] = '{2'b01, 0,   0,  6,    48, 1, 0};  // fresh full run after abort
    vecs[5] = '{2'b11, 0,   0,  0,    0,  0, 1};  // invalid amount code
    vecs[6] = '{2'b10, 40,  0,  4,    32, 0, 1};  // abort exactly at a rising point
    vecs[7] = '{2'b00, 48,  0,  5,    40, 0, 1};  // abort on the completion edge wins
    vecs[8] = '{2'b00, 49,  0,  5,    40, 1, 0};  // flag falls one cycle after DONE

    repeat (3) @(posedge clk);
    #1;
    check("rst_step",  W'(step_o),      W'(0));
    check("rst_dir",   W'(dir_o),       W'(0));
    check("rst_dc_en", W'(dc_en_o),     W'(0));
    check("rst_busy",  W'(busy_o),      W'(0));
    check("rst_hs",    W'(handshake_o), W'(0));
    check("rst_err",   W'(err_o),       W'(0));
    check("rst_state", W'(state_o),     W'(ST_IDLE));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset during the second step pulse, flag held: outputs clear, then a full new run.
    clear_counters();
    amount_i     = 2'b00;
    candy_flag_i = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("mid_step_high", W'(step_o), W'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_outputs", W'({step_o, dc_en_o, busy_o, handshake_o, err_o}), W'(0));
    check("mid_rst_state",   W'(state_o), W'(ST_IDLE));
    rst = 1'b0;
    run_vec(vecs[0], "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
